// File: rtl/game_state_ctrl.sv
// Match-level state machine for a two-player paddle game: start screen, serve
// delay, live play, and a winner screen with a minimum display time.
module game_state_ctrl #(
   parameter int unsigned WIN_SCORE    = 5,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned OVER_FRAMES  = 120
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       start_btn,
   input  logic       point_p1,
   input  logic       point_p2,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       player_won,
   output logic       ball_enable,
   output logic [1:0] screen_sel
);

   localparam logic [3:0] WinScore   = 4'(WIN_SCORE);
   localparam logic [7:0] ServeLast  = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] OverFrames = 8'(OVER_FRAMES);

   localparam logic [1:0] SelStart  = 2'd0;
   localparam logic [1:0] SelField  = 2'd1;
   localparam logic [1:0] SelWinner = 2'd2;

   typedef enum logic [1:0] {StIdle, StServe, StPlay, StOver} state_e;

   state_e     state_q;
   logic [7:0] frame_cnt_q;
   logic       vsync_q;
   logic       start_q;
   logic       start_armed_q;
   logic       frame_tick;
   logic       start_evt;
   logic [3:0] p1_inc;
   logic [3:0] p2_inc;

   // A start edge also needs start_btn to have been seen low since reset, so a
   // button held through reset release cannot start a match.
   assign frame_tick = vsync_in & ~vsync_q;
   assign start_evt  = start_btn & ~start_q & start_armed_q;
   assign p1_inc     = score_p1 + 4'd1;
   assign p2_inc     = score_p2 + 4'd1;

   // Previous-value registers for vsync/start edge detection.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vsync_q       <= 1'b0;
         start_q       <= 1'b0;
         start_armed_q <= 1'b0;
      end else begin
         vsync_q <= vsync_in;
         start_q <= start_btn;
         if (!start_btn) start_armed_q <= 1'b1;
      end
   end

   // Game FSM; all outputs are registered and change on the transition edge.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= StIdle;
         frame_cnt_q <= 8'd0;
         score_p1    <= 4'd0;
         score_p2    <= 4'd0;
         player_won  <= 1'b0;
         ball_enable <= 1'b0;
         screen_sel  <= SelStart;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_evt) begin
                  state_q     <= StServe;
                  frame_cnt_q <= 8'd0;
                  score_p1    <= 4'd0;
                  score_p2    <= 4'd0;
                  screen_sel  <= SelField;
                  ball_enable <= 1'b0;
               end
            end
            StServe: begin
               if (frame_tick) begin
                  if (frame_cnt_q == ServeLast) begin
                     state_q     <= StPlay;
                     frame_cnt_q <= 8'd0;
                     ball_enable <= 1'b1;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + 8'd1;
                  end
               end
            end
            StPlay: begin
               // Player 1 has priority on simultaneous point pulses.
               if (point_p1) begin
                  score_p1    <= p1_inc;
                  ball_enable <= 1'b0;
                  frame_cnt_q <= 8'd0;
                  if (p1_inc == WinScore) begin
                     state_q    <= StOver;
                     player_won <= 1'b0;
                     screen_sel <= SelWinner;
                  end else begin
                     state_q <= StServe;
                  end
               end else if (point_p2) begin
                  score_p2    <= p2_inc;
                  ball_enable <= 1'b0;
                  frame_cnt_q <= 8'd0;
                  if (p2_inc == WinScore) begin
                     state_q    <= StOver;
                     player_won <= 1'b1;
                     screen_sel <= SelWinner;
                  end else begin
                     state_q <= StServe;
                  end
               end
            end
            StOver: begin
               // Early start presses are dropped, not queued.
               if (start_evt && frame_cnt_q == OverFrames) begin
                  state_q     <= StServe;
                  frame_cnt_q <= 8'd0;
                  score_p1    <= 4'd0;
                  score_p2    <= 4'd0;
                  screen_sel  <= SelField;
               end else if (frame_tick && frame_cnt_q != OverFrames) begin
                  frame_cnt_q <= frame_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q     <= StIdle;
               frame_cnt_q <= 8'd0;
               ball_enable <= 1'b0;
               screen_sel  <= SelStart;
            end
         endcase
      end
   end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, meaning the point total that ends a match (legal range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning the frames the ball is held before each serve (legal range 1..255).
REQ-003 SHALL have parameter OVER_FRAMES, default 120, meaning the minimum frames the winner screen is shown before a restart is accepted (legal range 1..255).
REQ-004 SHALL have port pclk, input, 1 bit: pixel clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port vsync_in, input, 1 bit: vsync from the timing generator; its rising edge is the frame tick.
REQ-007 SHALL have port start_btn, input, 1 bit: start/restart button, already synchronised to pclk and debounced; its rising edge is the start event.
REQ-008 SHALL have port point_p1, input, 1 bit: single-cycle pulse meaning player 1 scored.
REQ-009 SHALL have port point_p2, input, 1 bit: single-cycle pulse meaning player 2 scored.
REQ-010 SHALL have port score_p1, output, 4 bits: player 1 score.
REQ-011 SHALL have port score_p2, output, 4 bits: player 2 score.
REQ-012 SHALL have port player_won, output, 1 bit: match winner; 0 = player 1, 1 = player 2; feeds the winner screen.
REQ-013 SHALL have port ball_enable, output, 1 bit: ball motion allowed.
REQ-014 SHALL have port screen_sel, output, 2 bits: display mux select; 0 = start screen, 1 = game field, 2 = winner screen.

Function
REQ-015 SHALL generate internal pulses frame_tick and start_evt, each high for one cycle when the registered previous value of vsync_in or start_btn (respectively) is 0 and the current value is 1.
REQ-016 SHALL implement an FSM with states IDLE, SERVE, PLAY and OVER, with every output registered.
REQ-017 IDLE: screen_sel=0, ball_enable=0, scores held at 0; on start_evt go to SERVE, clear the frame counter and clear both scores.
REQ-018 SERVE: screen_sel=1, ball_enable=0; count frame_tick; go to PLAY on the cycle the count reaches SERVE_FRAMES.
REQ-019 PLAY: screen_sel=1, ball_enable=1; a point pulse increments its score on the next clock edge.
REQ-020 In PLAY, if the incremented score equals WIN_SCORE, go to OVER in the same edge that updates the score, and set player_won to the scorer (0 = player 1, 1 = player 2); otherwise go to SERVE and clear the frame counter.
REQ-021 If point_p1 and point_p2 are both high in the same cycle, point_p1 wins; point_p2 is discarded.
REQ-022 Point pulses SHALL be ignored in IDLE, SERVE and OVER.
REQ-023 OVER: screen_sel=2, ball_enable=0; scores and player_won are frozen; count frame_tick, saturating at OVER_FRAMES.
REQ-024 In OVER, start_evt is accepted only once the count has reached OVER_FRAMES; it then goes to SERVE, clears both scores and the counter, and keeps player_won.
REQ-025 An earlier start_evt in OVER is discarded; it is not remembered.
REQ-026 start_evt in SERVE or PLAY SHALL have no effect.
REQ-027 The frame counter SHALL be 8 bits, SHALL be cleared on every state entry, and SHALL never wrap.
REQ-028 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-029 ball_enable SHALL fall on the same edge as any PLAY exit, so the ball is stopped in the first cycle of SERVE or OVER.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, score_p1=0, score_p2=0, player_won=0, ball_enable=0, screen_sel=0, frame counter=0, and both edge-detect registers=0.
REQ-031 A reset asserted in any state, mid-serve or mid-match included, SHALL take effect at the next edge; no score or winner value survives it.
REQ-032 A start_btn held high through reset release SHALL NOT produce start_evt; a fresh 0-to-1 transition is required.

Verification
REQ-033 Reset then start_btn edge -> SERVE with screen_sel=1; after 60 vsync rising edges, ball_enable=1 (SERVE_FRAMES=60).
REQ-034 In PLAY, 5 point_p2 pulses each followed by a serve -> score_p2=5, player_won=1, screen_sel=2 and ball_enable=0 on the edge after the 5th pulse.
REQ-035 point_p1 and point_p2 in the same PLAY cycle -> score_p1 increments by 1, score_p2 unchanged, next state SERVE.
REQ-036 In OVER, start edge after 10 frames -> ignored; start edge after 120 frames -> SERVE with scores 0/0 and player_won retained.
REQ-037 Point pulses during SERVE, and a start edge during PLAY -> no change to scores or state.
REQ-038 rst pulsed with score 4:3 in PLAY -> next cycle all outputs are at their reset values; start_btn held high through the reset release gives no start.
